// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the synchronous FIFO.
// DefaultDataWidth / DefaultDepth : default word width and entry count.
// fill_count_t                    : occupancy type for a default-depth FIFO (one bit wider than
//                                   the pointer so that "exactly full" is representable).
package sync_fifo_pkg;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultDepth     = 256;

  typedef logic [$clog2(DefaultDepth):0] fill_count_t;

endpackage

// File: rtl/sfifo_ram.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port.
// Contents are never reset.
// Ports:
//   clk_i   : write clock (rising edge)
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module sfifo_ram #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 256,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags and one-cycle error pulses.
// Optional feature: define SYNC_FIFO_FWFT_EN for first-word-fall-through output
// (data_out shows the head word combinationally while not empty); otherwise data_out is
// registered on each accepted read and held at all other times.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   flush        : synchronous clear of pointers/count/flags (memory, data_out untouched)
//   w_en, r_en   : write / read requests
//   data_in      : write data
//   data_out     : read data
//   full, empty, almost_full, almost_empty : registered status flags
//   fill_count   : current occupancy
//   write_error  : one-cycle pulse after a write attempted while full
//   read_error   : one-cycle pulse after a read attempted while empty
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned AFULL_LVL  = DEPTH - 4,
  parameter int unsigned AEMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    fill_count,
  output logic                  write_error,
  output logic                  read_error
);

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [PTR_WIDTH:0]   cnt_t;

  localparam ptr_t PtrOne    = ptr_t'(1);
  localparam cnt_t CntOne    = cnt_t'(1);
  localparam cnt_t DepthCnt  = cnt_t'(DEPTH);
  localparam cnt_t AfullCnt  = cnt_t'(AFULL_LVL);
  localparam cnt_t AemptyCnt = cnt_t'(AEMPTY_LVL);

  ptr_t wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t count_q, count_d;
  logic full_q, empty_q, afull_q, aempty_q, werr_q, rerr_q;
  logic werr_d, rerr_d;
  logic wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    // Acceptance looks only at the registered flags: a same-cycle read never frees space.
    wr_acc  = w_en & ~full_q & ~flush;
    rd_acc  = r_en & ~empty_q & ~flush;
    werr_d  = w_en & full_q & ~flush;
    rerr_d  = r_en & empty_q & ~flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (wr_acc) wptr_d = wptr_q + PtrOne;
      if (rd_acc) rptr_d = rptr_q + PtrOne;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      werr_q   <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      // Flags come from the next-state count so they line up with it, no lag.
      full_q   <= (count_d == DepthCnt);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AfullCnt);
      aempty_q <= (count_d <= AemptyCnt);
      werr_q   <= werr_d;
      rerr_q   <= rerr_d;
    end
  end

  // Writes are gated by rst_n so an access in a reset cycle is discarded entirely.
  sfifo_ram #(
    .DataWidth(DATA_WIDTH),
    .Depth    (DEPTH),
    .AddrWidth(PTR_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_acc & rst_n),
    .waddr_i(wptr_q),
    .wdata_i(data_in),
    .raddr_i(rptr_q),
    .rdata_o(ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible as soon as the FIFO is non-empty; drive zero while empty.
  assign data_out = empty_q ? '0 : ram_rdata;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= ram_rdata;
    end
  end

  assign data_out = dout_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign fill_count   = count_q;
  assign write_error  = werr_q;
  assign read_error   = rerr_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int Depth  = 8;
  localparam int Afull  = 6;
  localparam int Aempty = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] fill_count;
  logic       write_error, read_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];     // reference FIFO contents
  logic [7:0] exp_q[$];  // scoreboard: words the DUT must return, in order
  int         e_werr = 0;
  int         e_rerr = 0;

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (Depth),
    .AFULL_LVL (Afull),
    .AEMPTY_LVL(Aempty)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .w_en        (w_en),
    .r_en        (r_en),
    .data_in     (data_in),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fill_count  (fill_count),
    .write_error (write_error),
    .read_error  (read_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp,
               exp, $time);
    end
  endtask

  // One clock cycle: update the reference model, apply inputs, check status after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic fl,
                      input logic rs);
    int sz;
    w_en = w; r_en = r; data_in = d; flush = fl; rst_n = rs;
    if (!rs || fl) begin
      mq.delete();
      e_werr = 0;
      e_rerr = 0;
    end else begin
      sz     = mq.size();
      e_werr = (w && sz == Depth) ? 1 : 0;
      e_rerr = (r && sz == 0) ? 1 : 0;
      if (r && sz != 0) exp_q.push_back(mq.pop_front());
      if (w && sz != Depth) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    sz = mq.size();
    chk("fill_count", int'(fill_count), sz);
    chk("full", int'(full), (sz == Depth) ? 1 : 0);
    chk("empty", int'(empty), (sz == 0) ? 1 : 0);
    chk("almost_full", int'(almost_full), (sz >= Afull) ? 1 : 0);
    chk("almost_empty", int'(almost_empty), (sz <= Aempty) ? 1 : 0);
    chk("write_error", int'(write_error), e_werr);
    chk("read_error", int'(read_error), e_rerr);
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; flush = 1'b0; rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a read.
  initial begin
    logic       fire;
    logic [7:0] got;
    logic [7:0] exp;
    forever begin
      @(posedge clk);
      fire = r_en && !empty && rst_n && !flush;
      got  = data_out;  // pre-edge value: the head word in fall-through mode
`ifndef SYNC_FIFO_FWFT_EN
      @(negedge clk);
      got = data_out;
`endif
      if (fire) begin
        if (exp_q.size() == 0) begin
          chk("read_data_unexpected", int'(got), -1);
        end else begin
          exp = exp_q.pop_front();
          chk("read_data", int'(got), int'(exp));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected %0s", "completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_data_out", int'(data_out), 0);

    // Read while empty after reset.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("empty_read_data_out", int'(data_out), 0);
`endif
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill 0x01..0x08, overflow attempt with 0x09, then drain.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0, 1'b1);
`ifdef SYNC_FIFO_FWFT_EN
      if (i == 1) chk("fwft_first_word", int'(data_out), 1);
`endif
    end
    step(1'b1, 1'b0, 8'h09, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Threshold walk: fill to 6, read 5, read 1.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // Fill to 5, then 20 cycles of simultaneous read/write across pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // Flush beats a same-cycle write; following word comes back cleanly.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // Randomised traffic including rare flushes and mid-operation resets.
    for (int i = 0; i < 400; i++) begin
      logic w, r, fl, rs;
      int bias;
      bias = (i / 50) % 2 == 0 ? 70 : 30;
      w    = ($urandom_range(0, 99) < bias);
      r    = ($urandom_range(0, 99) < (100 - bias));
      fl   = ($urandom_range(0, 39) == 0);
      rs   = ($urandom_range(0, 79) != 0);
      step(w, r, 8'($urandom), fl, rs);
    end
    while (mq.size() != 0) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
